// File: rtl/count_display_driver_pkg.sv
// Shared types and constants for the count display driver and its 7-segment decoder.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anode patterns are one-cold.
package count_display_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF      = 4'b1111;
  localparam logic [3:0] AN_ONES     = 4'b1110;
  localparam logic [3:0] AN_TENS     = 4'b1101;
  localparam logic [3:0] AN_HUNDREDS = 4'b1011;
  localparam logic [3:0] AN_SPARE    = 4'b0111;

  // Shift-add-3 correction applied to each BCD nibble before every shift.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/count_display_driver_if.sv
// Bus between the upstream counter / display consumer and the count display driver.
interface count_display_driver_if;

  logic [7:0]  value;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [11:0] bcd;
  logic        bcd_valid;

  modport master (
    output value, ovf,
    input  an, seg, dp, bcd, bcd_valid
  );

  modport slave (
    input  value, ovf,
    output an, seg, dp, bcd, bcd_valid
  );

endinterface

// File: rtl/count_display_driver_seg7_decoder.sv
// Combinational nibble-to-7-segment decoder, active-low outputs.
// Nibbles above 9 and an asserted blank both produce an unlit digit.
module seg7_decoder
  import count_display_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (nibble_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// Shows an 8-bit count as decimal 000-255 on a 4-digit multiplexed common-anode display.
// A 10-cycle shift-add-3 converter feeds the BCD register; a prescaled scan picks the digit.
module count_display_driver
  import count_display_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  count_display_driver_if.slave bus
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  conv_state_e       state_q, state_d;
  logic [7:0]        shadow_q, shadow_d;
  logic              shadowOvf_q, shadowOvf_d;
  logic [11:0]       scratch_q, scratch_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [11:0]       bcd_q, bcd_d;
  logic              ovfDisp_q, ovfDisp_d;
  logic              bcdValid_q, bcdValid_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        digit_q, digit_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic [11:0]       adjusted;
  logic [3:0]        nibble;
  logic              blank;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    shadowOvf_d = shadowOvf_q;
    scratch_d   = scratch_q;
    bitCnt_d    = bitCnt_q;
    bcd_d       = bcd_q;
    ovfDisp_d   = ovfDisp_q;
    bcdValid_d  = 1'b0;
    adjusted    = {add3_if_ge5(scratch_q[11:8]), add3_if_ge5(scratch_q[7:4]),
                   add3_if_ge5(scratch_q[3:0])};
    case (state_q)
      IDLE: begin
        shadow_d    = bus.value;
        shadowOvf_d = bus.ovf;
        scratch_d   = '0;
        bitCnt_d    = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        {scratch_d, shadow_d} = {adjusted[10:0], shadow_q, 1'b0};
        bitCnt_d = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) state_d = LATCH;
      end
      LATCH: begin
        bcd_d      = scratch_q;
        ovfDisp_d  = shadowOvf_q;
        bcdValid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit selection; the display registers lag the digit index by one cycle.
  always_comb begin
    scan_d  = scan_q + SCAN_W'(1);
    digit_d = digit_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end

    nibble = bcd_q[3:0];
    blank  = 1'b0;
    an_d   = AN_ONES;
    dp_d   = ~ovfDisp_q;
    case (digit_q)
      2'd0: ;
      2'd1: begin
        nibble = bcd_q[7:4];
        blank  = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
        an_d   = AN_TENS;
        dp_d   = 1'b1;
      end
      2'd2: begin
        nibble = bcd_q[11:8];
        blank  = BLANK_LZ && (bcd_q[11:8] == 4'd0);
        an_d   = AN_HUNDREDS;
        dp_d   = 1'b1;
      end
      default: begin
        blank = 1'b1;
        an_d  = AN_SPARE;
        dp_d  = 1'b1;
      end
    endcase
  end

  seg7_decoder u_decoder (
    .nibble_i (nibble),
    .blank_i  (blank),
    .seg_o    (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      shadowOvf_q <= 1'b0;
      scratch_q   <= '0;
      bitCnt_q    <= '0;
      bcd_q       <= '0;
      ovfDisp_q   <= 1'b0;
      bcdValid_q  <= 1'b0;
      scan_q      <= '0;
      digit_q     <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      shadowOvf_q <= shadowOvf_d;
      scratch_q   <= scratch_d;
      bitCnt_q    <= bitCnt_d;
      bcd_q       <= bcd_d;
      ovfDisp_q   <= ovfDisp_d;
      bcdValid_q  <= bcdValid_d;
      scan_q      <= scan_d;
      digit_q     <= digit_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcdValid_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Testbench for count_display_driver: three instances (scan 4 / blanking on, scan 4 / blanking off,
// scan 2 / blanking on) share one stimulus; converted values are tracked through a scoreboard queue.
module tb_count_display_driver;

  typedef struct {
    logic [7:0]  value;
    logic        ovf;
    logic [11:0] expBcd;
    logic [6:0]  segOnes;
    logic [6:0]  segTens;
    logic [6:0]  segHund;
    logic [6:0]  segTensNoLz;
    logic [6:0]  segHundNoLz;
    logic        dpOnes;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  value = 8'd0;
  logic        ovf = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          edgeNo = 0;
  logic [11:0] expQ[$];

  logic        collect = 1'b0;
  logic [6:0]  segSeenA[4];
  logic [6:0]  segSeenB[4];
  logic        dpSeenA[4];
  logic        conflictA[4];
  logic        seenA[4];

  count_display_driver_if busA();
  count_display_driver_if busB();
  count_display_driver_if busC();

  assign busA.value = value;
  assign busA.ovf   = ovf;
  assign busB.value = value;
  assign busB.ovf   = ovf;
  assign busC.value = value;
  assign busC.ovf   = ovf;

  always #5 clk = ~clk;

  count_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dutA (.clk(clk), .rst(rst), .bus(busA));
  count_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dutB (.clk(clk), .rst(rst), .bus(busB));
  count_display_driver #(.SCAN_DIV(2), .BLANK_LZ(1'b1)) dutC (.clk(clk), .rst(rst), .bus(busC));

  function automatic logic [3:0] anPattern(input int idx);
    case (idx)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic int anIndex(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edgeNo);
    end
  endtask

  // Drive one capture value and record the BCD it must produce.
  task automatic applyStimulus(input logic [7:0] v, input logic o, input logic [11:0] exp);
    value = v;
    ovf   = o;
    expQ.push_back(exp);
  endtask

  // One clock; checks scan order, bcd_valid cadence and scoreboard at the following negedge.
  task automatic nextEdge();
    logic [11:0] exp;
    int          idx;
    @(posedge clk);
    edgeNo++;
    @(negedge clk);
    checkOutput("an_A", 32'(busA.an), 32'(anPattern(((edgeNo - 1) / 4) % 4)));
    checkOutput("an_B", 32'(busB.an), 32'(anPattern(((edgeNo - 1) / 4) % 4)));
    checkOutput("an_C", 32'(busC.an), 32'(anPattern(((edgeNo - 1) / 2) % 4)));
    if (busA.an == 4'b0111) checkOutput("seg_spare_A", 32'(busA.seg), 32'h7f);
    if (busC.an == 4'b0111) checkOutput("seg_spare_C", 32'(busC.seg), 32'h7f);
    checkOutput("bcd_valid_A", 32'(busA.bcd_valid), 32'(edgeNo % 10 == 0));
    checkOutput("bcd_valid_C", 32'(busC.bcd_valid), 32'(edgeNo % 10 == 0));
    if (busA.bcd_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard: unexpected bcd_valid, got bcd 0x%0h (edge %0d)", busA.bcd, edgeNo);
      end else begin
        exp = expQ.pop_front();
        checkOutput("bcd_A", 32'(busA.bcd), 32'(exp));
        checkOutput("bcd_B", 32'(busB.bcd), 32'(exp));
        checkOutput("bcd_C", 32'(busC.bcd), 32'(exp));
      end
    end
    if (collect) begin
      idx = anIndex(busA.an);
      if (idx >= 0) begin
        if (seenA[idx] && ((segSeenA[idx] != busA.seg) || (dpSeenA[idx] != busA.dp)))
          conflictA[idx] = 1'b1;
        segSeenA[idx] = busA.seg;
        dpSeenA[idx]  = busA.dp;
        seenA[idx]    = 1'b1;
      end
      idx = anIndex(busB.an);
      if (idx >= 0) segSeenB[idx] = busB.seg;
    end
  endtask

  // Three passes of one value; the display is observed over the last two (stable bcd).
  task automatic runVector(input vec_t v);
    applyStimulus(v.value, v.ovf, v.expBcd);
    repeat (10) nextEdge();
    for (int d = 0; d < 4; d++) begin
      segSeenA[d]  = 7'h00;
      segSeenB[d]  = 7'h00;
      dpSeenA[d]   = 1'b0;
      conflictA[d] = 1'b0;
      seenA[d]     = 1'b0;
    end
    collect = 1'b1;
    repeat (2) begin
      applyStimulus(v.value, v.ovf, v.expBcd);
      repeat (10) nextEdge();
    end
    collect = 1'b0;
    checkOutput($sformatf("v%0d seg_ones", v.value), 32'(segSeenA[0]), 32'(v.segOnes));
    checkOutput($sformatf("v%0d seg_tens", v.value), 32'(segSeenA[1]), 32'(v.segTens));
    checkOutput($sformatf("v%0d seg_hund", v.value), 32'(segSeenA[2]), 32'(v.segHund));
    checkOutput($sformatf("v%0d seg_spare", v.value), 32'(segSeenA[3]), 32'h7f);
    checkOutput($sformatf("v%0d seg_tens_nolz", v.value), 32'(segSeenB[1]), 32'(v.segTensNoLz));
    checkOutput($sformatf("v%0d seg_hund_nolz", v.value), 32'(segSeenB[2]), 32'(v.segHundNoLz));
    checkOutput($sformatf("v%0d dp_ones", v.value), 32'(dpSeenA[0]), 32'(v.dpOnes));
    for (int d = 1; d < 4; d++)
      checkOutput($sformatf("v%0d dp_digit%0d", v.value, d), 32'(dpSeenA[d]), 32'h1);
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("v%0d seen_digit%0d", v.value, d), 32'(seenA[d]), 32'h1);
      checkOutput($sformatf("v%0d stable_digit%0d", v.value, d), 32'(conflictA[d]), 32'h0);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " an_A"}, 32'(busA.an), 32'hf);
    checkOutput({tag, " seg_A"}, 32'(busA.seg), 32'h7f);
    checkOutput({tag, " dp_A"}, 32'(busA.dp), 32'h1);
    checkOutput({tag, " bcd_A"}, 32'(busA.bcd), 32'h0);
    checkOutput({tag, " bcd_valid_A"}, 32'(busA.bcd_valid), 32'h0);
    checkOutput({tag, " an_C"}, 32'(busC.an), 32'hf);
    checkOutput({tag, " bcd_B"}, 32'(busB.bcd), 32'h0);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{8'd123, 1'b0, 12'h123, 7'b0110000, 7'b0100100, 7'b1111001, 7'b0100100, 7'b1111001, 1'b1};
    vecs[1] = '{8'd255, 1'b1, 12'h255, 7'b0010010, 7'b0010010, 7'b0100100, 7'b0010010, 7'b0100100, 1'b0};
    vecs[2] = '{8'd7,   1'b0, 12'h007, 7'b1111000, 7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000, 1'b1};
    vecs[3] = '{8'd0,   1'b0, 12'h000, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000, 1'b1};
    vecs[4] = '{8'd40,  1'b0, 12'h040, 7'b1000000, 7'b0011001, 7'b1111111, 7'b0011001, 7'b1000000, 1'b1};
    vecs[5] = '{8'd109, 1'b0, 12'h109, 7'b0010000, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1111001, 1'b1};
    vecs[6] = '{8'd98,  1'b0, 12'h098, 7'b0000000, 7'b0010000, 7'b1111111, 7'b0010000, 7'b1000000, 1'b1};
    vecs[7] = '{8'd200, 1'b0, 12'h200, 7'b1000000, 7'b1000000, 7'b0100100, 7'b1000000, 7'b0100100, 1'b1};

    // Held in reset with a nonzero input.
    value = 8'd123;
    ovf   = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");

    // First conversion: pulse on edge 10 only, again on edge 20.
    rst    = 1'b0;
    edgeNo = 0;
    applyStimulus(8'd123, 1'b0, 12'h123);
    repeat (9) nextEdge();
    checkOutput("first bcd before edge10", 32'(busA.bcd), 32'h0);
    nextEdge();
    checkOutput("first bcd_valid edge10", 32'(busA.bcd_valid), 32'h1);
    applyStimulus(8'd123, 1'b0, 12'h123);
    nextEdge();
    checkOutput("first bcd held edge11", 32'(busA.bcd), 32'h123);
    repeat (9) nextEdge();

    for (int i = 0; i < 8; i++) runVector(vecs[i]);

    // Input change after capture must not disturb the pass in progress.
    applyStimulus(8'd100, 1'b0, 12'h100);
    repeat (3) nextEdge();
    value = 8'd200;
    repeat (7) nextEdge();
    applyStimulus(8'd200, 1'b0, 12'h200);
    repeat (10) nextEdge();

    // Reset during the 4th shift aborts the pass without a bcd_valid.
    applyStimulus(8'd77, 1'b0, 12'h077);
    repeat (4) nextEdge();
    rst = 1'b1;
    void'(expQ.pop_back());
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midreset");
    rst    = 1'b0;
    edgeNo = 0;
    applyStimulus(8'd77, 1'b0, 12'h077);
    repeat (10) nextEdge();

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 8-bit free-running counter. Takes its count and ovf outputs and shows the count as a decimal value (000–255) on a 4-digit, common-anode, multiplexed 7-segment display.
- Binary-to-BCD conversion is sequential (shift-add-3, one bit per cycle).
- Digits are time-multiplexed by a prescaled scan counter.
- The latest BCD result is exported for other consumers.

Parameters:
- SCAN_DIV, 100000, clock cycles each digit stays active (1 kHz digit rate at 100 MHz); legal range ≥2.
- BLANK_LZ, 1, 1 = blank leading zeros on hundreds/tens; 0 = always show three digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  8  binary count from upstream counter.
- ovf  in  1  upstream overflow flag (high when value==255).
- an  out  4  digit anodes, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=unused digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- bcd  out  12  last converted value {hundreds,tens,ones}, 4 bits each.
- bcd_valid  out  1  one-cycle pulse when bcd updates.

Behaviour:
- Reset state (all registered outputs):
  - an=4'b1111, seg=7'b1111111, dp=1, bcd=0, bcd_valid=0.
  - FSM=IDLE, scan counter=0, digit index=0.
- Reset mid-operation aborts any conversion. No bcd_valid is produced for the aborted pass.
- Converter FSM, fixed 10-cycle period:
  - IDLE, 1 cycle: capture value and ovf into shadow registers; clear BCD scratch and bit counter; go to SHIFT.
  - SHIFT, 8 cycles: each cycle add 3 to every scratch nibble ≥5, then shift {scratch, shadow} left by 1. After the 8th shift go to LATCH.
  - LATCH, 1 cycle: bcd<=scratch, ovf_disp<=shadow ovf, bcd_valid<=1 for this cycle only; go to IDLE.
- Conversion timing:
  - After rst deasserts, the first bcd update and bcd_valid pulse occur on rising edge 10, then every 10 cycles.
  - value/ovf changes after capture do not affect the pass in progress.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 and wraps. On wrap, digit index advances 0→1→2→3→0.
  - an, seg and dp are registered from the current digit index and bcd, so they lag the index by 1 cycle.
- Digit content:
  - Digit 0: ones, never blanked.
  - Digit 1: tens, blanked if BLANK_LZ and hundreds==0 and tens==0.
  - Digit 2: hundreds, blanked if BLANK_LZ and hundreds==0.
  - Digit 3: always blanked (seg=7'b1111111); its anode still cycles.
- dp=0 only while digit 0 is active and ovf_disp=1; otherwise dp=1.
- Segment codes, 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Nibbles >9 are impossible by construction; the decoder drives blank for them.

Decomposition:
- Shared include/header holds:
  - FSM state localparams: IDLE, SHIFT, LATCH.
  - Segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - Anode one-cold patterns.
- One natural sub-module: seg7_decoder, combinational, 4-bit nibble + blank → 7-bit active-low pattern. It is reusable by other display blocks.
- Converter FSM and scan logic stay in the top module.

Test Plan (SCAN_DIV=4 unless noted):
- Reset/first conversion: rst high with value=123 → an=1111, seg=1111111, bcd=0. Release rst → bcd=12'h123 with bcd_valid high for exactly 1 cycle at edge 10, then again at edge 20.
- Max/overflow: value=255, ovf=1 → bcd=12'h255; dp=0 only while an=1110, dp=1 on the other digits.
- Leading-zero blanking: value=7, BLANK_LZ=1 → hundreds and tens show seg=1111111, ones shows 1111000. With BLANK_LZ=0, value=7 → hundreds and tens show 1000000.
- Mid-pass change: value=100 at capture, switched to 200 during SHIFT → that pass gives bcd=12'h100, the next pass gives 12'h200.
- Scan sequence: an cycles 1110→1101→1011→0111→1110, each held 4 cycles, seg=1111111 whenever an=0111. Repeat with SCAN_DIV=2 and confirm 2-cycle hold.
- Reset mid-SHIFT: assert rst for 1 cycle during the 4th shift → next cycle all outputs at reset values, no bcd_valid. After release, the first bcd_valid comes 10 edges later with the correct value.
